// File: rtl/pll_reconfig_pkg.sv
// Shared types and constants for the PLL reconfiguration master: FSM states,
// management register map, counter-word layout and the four output profiles.
package pll_reconfig_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_MODE,
    S_WR_N,
    S_WR_M,
`ifdef RECONFIG_VERIFY_EN
    S_RD_N,
    S_RD_M,
`endif
    S_WR_C,
    S_WR_START,
    S_POLL_STATUS,
    S_WAIT_LOCK,
    S_ERROR
  } state_e;

  localparam int unsigned REG_MODE   = 0;
  localparam int unsigned REG_STATUS = 1;
  localparam int unsigned REG_START  = 2;
  localparam int unsigned REG_N      = 3;
  localparam int unsigned REG_M      = 4;
  localparam int unsigned REG_C      = 5;

  localparam int CW_LO_LSB     = 0;
  localparam int CW_HI_LSB     = 8;
  localparam int CW_BYPASS_BIT = 16;
  localparam int CW_ODD_BIT    = 17;
  localparam int CW_IDX_LSB    = 18;

  typedef struct packed {
    logic [31:0] n;
    logic [31:0] m;
    logic [31:0] c0;
  } profile_t;

  function automatic logic [31:0] cnt_word(input logic [4:0] idx, input logic [7:0] hi,
                                           input logic [7:0] lo, input logic bypass,
                                           input logic odd);
    cnt_word = (32'(idx) << CW_IDX_LSB) | (32'(odd) << CW_ODD_BIT) |
               (32'(bypass) << CW_BYPASS_BIT) | (32'(hi) << CW_HI_LSB) |
               (32'(lo) << CW_LO_LSB);
  endfunction

  // 50 MHz ref, N bypassed, M = 12 -> VCO 600 MHz; C0 divides down to 10/5/20/50 MHz.
  localparam profile_t PROFILES [4] = '{
    '{n: cnt_word(5'd0, 8'd0, 8'd0, 1'b1, 1'b0),  m: cnt_word(5'd0, 8'd6, 8'd6, 1'b0, 1'b0),
      c0: cnt_word(5'd0, 8'h1E, 8'h1E, 1'b0, 1'b0)},
    '{n: cnt_word(5'd0, 8'd0, 8'd0, 1'b1, 1'b0),  m: cnt_word(5'd0, 8'd6, 8'd6, 1'b0, 1'b0),
      c0: cnt_word(5'd0, 8'h3C, 8'h3C, 1'b0, 1'b0)},
    '{n: cnt_word(5'd0, 8'd0, 8'd0, 1'b1, 1'b0),  m: cnt_word(5'd0, 8'd6, 8'd6, 1'b0, 1'b0),
      c0: cnt_word(5'd0, 8'h0F, 8'h0F, 1'b0, 1'b0)},
    '{n: cnt_word(5'd0, 8'd0, 8'd0, 1'b1, 1'b0),  m: cnt_word(5'd0, 8'd6, 8'd6, 1'b0, 1'b0),
      c0: cnt_word(5'd0, 8'h06, 8'h06, 1'b0, 1'b0)}
  };

endpackage

// File: rtl/pll_reconfig_ctrl_profile_rom.sv
// Combinational lookup from profile index to the N/M/C0 counter words.
module pll_profile_rom
  import pll_reconfig_pkg::*;
(
  input  logic [1:0] idx,
  output profile_t   prof
);

  assign prof = PROFILES[idx];

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// Avalon-MM master that writes a PLL profile, triggers reconfig, polls and qualifies lock.
// Optional RECONFIG_VERIFY_EN inserts N/M readback checks before the C0 write.
module pll_reconfig_ctrl
  import pll_reconfig_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int POLL_TIMEOUT       = 65535,
  parameter int LOCK_TIMEOUT       = 1000000,
  parameter int ADDR_W             = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        profile_sel,
  input  logic              pll_locked,
  output logic [ADDR_W-1:0] mgmt_address,
  output logic              mgmt_write,
  output logic              mgmt_read,
  output logic [31:0]       mgmt_writedata,
  input  logic [31:0]       mgmt_readdata,
  input  logic              mgmt_waitrequest,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        active_profile
);

  localparam int PW = (POLL_TIMEOUT > 1) ? $clog2(POLL_TIMEOUT) : 1;
  localparam int LW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int SW = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam logic [PW-1:0] POLL_LIM = PW'(POLL_TIMEOUT - 1);
  localparam logic [LW-1:0] LOCK_LIM = LW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] STAB_LIM = SW'(LOCK_STABLE_CYCLES - 1);

  state_e            state, state_nxt, tgt_next;
  logic [1:0]        sel_q, sel_nxt, act_nxt;
  logic [ADDR_W-1:0] addr_nxt, tgt_addr;
  logic [31:0]       data_nxt, tgt_word;
  logic              wr_nxt, rd_nxt, err_nxt, done_nxt;
  logic [PW-1:0]     poll_cnt, poll_nxt;
  logic [LW-1:0]     lock_cnt, lock_nxt;
  logic [SW-1:0]     stab_cnt, stab_nxt;
  profile_t          prof;
  logic              unused_rd;

  pll_profile_rom u_rom (
    .idx  (sel_q),
    .prof (prof)
  );

  assign busy = (state != S_IDLE) && (state != S_ERROR);

`ifdef RECONFIG_VERIFY_EN
  localparam int CMP_W = CW_ODD_BIT + 1;
  assign unused_rd = ^mgmt_readdata[31:CMP_W];
`else
  assign unused_rd = ^mgmt_readdata[31:1];
`endif

  // Register/word/successor for each bus-access state
  always_comb begin
    tgt_addr = '0;
    tgt_word = '0;
    tgt_next = S_IDLE;
    case (state)
      S_WR_MODE:     begin tgt_addr = ADDR_W'(REG_MODE);  tgt_word = 32'd1;   tgt_next = S_WR_N; end
      S_WR_N:        begin tgt_addr = ADDR_W'(REG_N);     tgt_word = prof.n;  tgt_next = S_WR_M; end
`ifdef RECONFIG_VERIFY_EN
      S_WR_M:        begin tgt_addr = ADDR_W'(REG_M);     tgt_word = prof.m;  tgt_next = S_RD_N; end
      S_RD_N:        begin tgt_addr = ADDR_W'(REG_N);     tgt_word = prof.n;  tgt_next = S_RD_M; end
      S_RD_M:        begin tgt_addr = ADDR_W'(REG_M);     tgt_word = prof.m;  tgt_next = S_WR_C; end
`else
      S_WR_M:        begin tgt_addr = ADDR_W'(REG_M);     tgt_word = prof.m;  tgt_next = S_WR_C; end
`endif
      S_WR_C:        begin tgt_addr = ADDR_W'(REG_C);     tgt_word = prof.c0; tgt_next = S_WR_START; end
      S_WR_START:    begin tgt_addr = ADDR_W'(REG_START); tgt_word = 32'd1;   tgt_next = S_POLL_STATUS; end
      S_POLL_STATUS: tgt_addr = ADDR_W'(REG_STATUS);
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    wr_nxt    = mgmt_write;
    rd_nxt    = mgmt_read;
    addr_nxt  = mgmt_address;
    data_nxt  = mgmt_writedata;
    err_nxt   = error;
    done_nxt  = 1'b0;
    sel_nxt   = sel_q;
    act_nxt   = active_profile;
    poll_nxt  = '0;
    lock_nxt  = '0;
    stab_nxt  = '0;
    case (state)
      S_IDLE, S_ERROR: begin
        if (start) begin
          sel_nxt   = profile_sel;
          err_nxt   = 1'b0;
          state_nxt = S_WR_MODE;
        end
      end
      // Issue the strobe one cycle after entry, then hold until the slave accepts
      S_WR_MODE, S_WR_N, S_WR_M, S_WR_C, S_WR_START: begin
        if (!mgmt_write) begin
          wr_nxt   = 1'b1;
          addr_nxt = tgt_addr;
          data_nxt = tgt_word;
        end else if (!mgmt_waitrequest) begin
          wr_nxt    = 1'b0;
          state_nxt = tgt_next;
        end
      end
`ifdef RECONFIG_VERIFY_EN
      S_RD_N, S_RD_M: begin
        if (!mgmt_read) begin
          rd_nxt   = 1'b1;
          addr_nxt = tgt_addr;
        end else if (!mgmt_waitrequest) begin
          rd_nxt = 1'b0;
          if (mgmt_readdata[CMP_W-1:0] == tgt_word[CMP_W-1:0]) begin
            state_nxt = tgt_next;
          end else begin
            state_nxt = S_ERROR;
            err_nxt   = 1'b1;
          end
        end
      end
`endif
      S_POLL_STATUS: begin
        poll_nxt = (poll_cnt == '1) ? poll_cnt : poll_cnt + PW'(1);
        if (!mgmt_read) begin
          rd_nxt   = 1'b1;
          addr_nxt = tgt_addr;
        end else if (!mgmt_waitrequest) begin
          rd_nxt = 1'b0;
          if (mgmt_readdata[0]) state_nxt = S_WAIT_LOCK;
        end
        if ((state_nxt == S_POLL_STATUS) && (poll_cnt == POLL_LIM)) begin
          state_nxt = S_ERROR;
          err_nxt   = 1'b1;
          rd_nxt    = 1'b0;
        end
      end
      S_WAIT_LOCK: begin
        lock_nxt = (lock_cnt == '1) ? lock_cnt : lock_cnt + LW'(1);
        if (pll_locked) stab_nxt = (stab_cnt == '1) ? stab_cnt : stab_cnt + SW'(1);
        if (pll_locked && (stab_cnt == STAB_LIM)) begin
          done_nxt  = 1'b1;
          act_nxt   = sel_q;
          state_nxt = S_IDLE;
        end else if (lock_cnt == LOCK_LIM) begin
          state_nxt = S_ERROR;
          err_nxt   = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      mgmt_write     <= 1'b0;
      mgmt_read      <= 1'b0;
      mgmt_address   <= '0;
      mgmt_writedata <= '0;
      error          <= 1'b0;
      done           <= 1'b0;
      sel_q          <= '0;
      active_profile <= '0;
      poll_cnt       <= '0;
      lock_cnt       <= '0;
      stab_cnt       <= '0;
    end else begin
      state          <= state_nxt;
      mgmt_write     <= wr_nxt;
      mgmt_read      <= rd_nxt;
      mgmt_address   <= addr_nxt;
      mgmt_writedata <= data_nxt;
      error          <= err_nxt;
      done           <= done_nxt;
      sel_q          <= sel_nxt;
      active_profile <= act_nxt;
      poll_cnt       <= poll_nxt;
      lock_cnt       <= lock_nxt;
      stab_cnt       <= stab_nxt;
    end
  end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Scoreboard bench for pll_reconfig_ctrl with a behavioural Avalon-MM slave model.
module tb_pll_reconfig_ctrl;

  localparam int LSC = 1024;
  localparam int PT  = 300;
  localparam int LT  = 3000;
  localparam int FREQ [4] = '{10, 5, 20, 50};

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  profile_sel = 2'd0;
  logic        pll_locked = 1'b1;
  logic [5:0]  mgmt_address;
  logic        mgmt_write, mgmt_read, mgmt_waitrequest;
  logic [31:0] mgmt_writedata, mgmt_readdata;
  logic        busy, done, error;
  logic [1:0]  active_profile;

  pll_reconfig_ctrl #(
    .LOCK_STABLE_CYCLES (LSC),
    .POLL_TIMEOUT       (PT),
    .LOCK_TIMEOUT       (LT),
    .ADDR_W             (6)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .profile_sel      (profile_sel),
    .pll_locked       (pll_locked),
    .mgmt_address     (mgmt_address),
    .mgmt_write       (mgmt_write),
    .mgmt_read        (mgmt_read),
    .mgmt_writedata   (mgmt_writedata),
    .mgmt_readdata    (mgmt_readdata),
    .mgmt_waitrequest (mgmt_waitrequest),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .active_profile   (active_profile)
  );

  always #5 clk = ~clk;

  typedef struct {int addr; logic [31:0] data;} wr_t;
  typedef struct {bit is_err; int prof; bit chk_time;} out_t;

  wr_t         exp_wr[$];
  out_t        exp_out[$];
  int          total = 0, bad = 0, cyc = 0;
  int          ws_cycles = 0, wcnt;
  bit          status_ok = 1'b1, corrupt_m = 1'b0, in_lock = 1'b0;
  int          model_active = 0, t_lock = 0, last_low = 0, t_start = 0;
  logic [31:0] regfile [64];

  always @(posedge clk) cyc <= cyc + 1;

  // Slave: stalls each transfer for ws_cycles, STATUS bit0 from status_ok, others read back
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) wcnt <= 0;
    else if (mgmt_write || mgmt_read) wcnt <= mgmt_waitrequest ? wcnt + 1 : 0;
    else wcnt <= 0;
  end
  assign mgmt_waitrequest = (mgmt_write || mgmt_read) && (wcnt < ws_cycles);
  always_comb begin
    mgmt_readdata = regfile[mgmt_address];
    if (mgmt_address == 6'd1) mgmt_readdata = {31'd0, status_ok};
    else if (mgmt_address == 6'd4 && corrupt_m) mgmt_readdata = 32'h0000_0605;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: counter word from a division ratio of the 600 MHz VCO / 50 MHz ref
  function automatic logic [31:0] cword(input int div);
    int hi, lo;
    if (div == 1) return 32'h0001_0000;
    hi = div / 2;
    lo = div - hi;
    return (32'(div % 2) << 17) | (32'(hi) << 8) | 32'(lo);
  endfunction

  task automatic push_writes(input int p, input bit upto_m);
    exp_wr.push_back('{0, 32'd1});
    exp_wr.push_back('{3, cword(1)});
    exp_wr.push_back('{4, cword(600 / 50)});
    if (!upto_m) begin
      exp_wr.push_back('{5, cword(600 / FREQ[p])});
      exp_wr.push_back('{2, 32'd1});
    end
  endtask

  // Monitor
  initial begin
    int  hold_len, ref_c;
    bit  prev_stall, done_prev, err_prev;
    logic [5:0]  prev_addr;
    logic [31:0] prev_data;
    wr_t  w;
    out_t o;
    for (int i = 0; i < 64; i++) regfile[i] = 32'd0;
    hold_len = 0; prev_stall = 0; done_prev = 0; err_prev = 0;
    prev_addr = '0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        hold_len = 0; prev_stall = 0; done_prev = 0; err_prev = 0;
      end else begin
        if (prev_stall) begin
          chk("hold_strobe", {31'd0, mgmt_write}, 32'd1);
          chk("hold_addr", {26'd0, mgmt_address}, {26'd0, prev_addr});
          chk("hold_data", mgmt_writedata, prev_data);
        end
        prev_stall = mgmt_write && mgmt_waitrequest;
        prev_addr  = mgmt_address;
        prev_data  = mgmt_writedata;
        if (mgmt_write) hold_len++;
        if (mgmt_write && !mgmt_waitrequest) begin
          chk("strobe_len", 32'(hold_len), 32'(ws_cycles + 1));
          hold_len = 0;
          regfile[mgmt_address] = mgmt_writedata;
          if (mgmt_address == 6'd2) t_start = cyc;
          if (exp_wr.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_write actual=%0h:%0h required=none", mgmt_address, mgmt_writedata);
          end else begin
            w = exp_wr.pop_front();
            chk("wr_addr", {26'd0, mgmt_address}, 32'(w.addr));
            chk("wr_data", mgmt_writedata, w.data);
          end
        end
        if (mgmt_read && !mgmt_waitrequest && mgmt_address == 6'd1 && mgmt_readdata[0]) begin
          t_lock = cyc; in_lock = 1'b1;
        end
        if (busy && !pll_locked) last_low = cyc;
        if (done) begin
          chk("done_single_cycle", {31'd0, done_prev}, 32'd0);
          if (exp_out.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_done actual=1 required=0");
          end else begin
            o = exp_out.pop_front();
            chk("done_kind", {31'd0, o.is_err}, 32'd0);
            chk("done_active", {30'd0, active_profile}, 32'(o.prof));
            chk("done_busy", {31'd0, busy}, 32'd0);
            ref_c = (t_lock > last_low) ? t_lock : last_low;
            chk("done_timing", 32'(cyc - ref_c), 32'(LSC + 1));
          end
        end
        if (error && !err_prev) begin
          if (exp_out.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_error actual=1 required=0");
          end else begin
            o = exp_out.pop_front();
            chk("err_kind", {31'd0, o.is_err}, 32'd1);
            chk("err_active", {30'd0, active_profile}, 32'(o.prof));
            chk("err_busy", {31'd0, busy}, 32'd0);
            if (o.chk_time) chk("err_timing", 32'(cyc - t_start), 32'(PT + 1));
          end
        end
        done_prev = done;
        err_prev  = error;
      end
    end
  end

  task automatic pulse_start(input int p, input bit check);
    @(posedge clk); #1;
    start = 1'b1; profile_sel = 2'(p);
    @(posedge clk); #1;
    start = 1'b0;
    if (check) begin
      chk("busy_on_start", {31'd0, busy}, 32'd1);
      chk("err_clr_on_start", {31'd0, error}, 32'd0);
    end
  endtask

  task automatic run(input int p, input int ws, input bit st_ok, input int drop_at,
                     input bit glitch, input bit verify_bad);
    int n;
    ws_cycles = ws; status_ok = st_ok; corrupt_m = verify_bad; in_lock = 1'b0;
    push_writes(p, verify_bad);
    if (!st_ok || verify_bad) exp_out.push_back('{1'b1, model_active, !verify_bad});
    else exp_out.push_back('{1'b0, p, 1'b0});
    pulse_start(p, 1'b1);
    if (glitch) begin
      repeat (2) @(posedge clk);
      pulse_start(3, 1'b0);
    end
    if (drop_at > 0) begin
      n = 0;
      while (!in_lock && n < 2000) begin @(posedge clk); n++; end
      repeat (drop_at) @(posedge clk);
      #1 pll_locked = 1'b0;
      @(posedge clk); #1 pll_locked = 1'b1;
    end
    n = 0;
    while (exp_out.size() != 0 && n < LT + PT + 2000) begin @(posedge clk); n++; end
    if (exp_out.size() != 0) begin
      total++; bad++;
      $display("FAIL outcome_timeout actual=pending required=done_or_error");
      exp_out.delete();
    end
    chk("writes_left", 32'(exp_wr.size()), 32'd0);
    exp_wr.delete();
    if (st_ok && !verify_bad) model_active = p;
    corrupt_m = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #3 reset_n = 1'b0;
    #2;
    chk("rst_write", {31'd0, mgmt_write}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_active", {30'd0, active_profile}, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    run(2, 0, 1'b1, 0, 1'b0, 1'b0);
    run(1, 3, 1'b1, 0, 1'b0, 1'b0);
    run(0, 1, 1'b0, 0, 1'b0, 1'b0);
    run(3, 0, 1'b1, 500, 1'b0, 1'b0);
    run(1, 0, 1'b1, 0, 1'b1, 1'b0);

    // Asynchronous reset while the M write is stalled on the bus
    ws_cycles = 3; status_ok = 1'b1;
    push_writes(2, 1'b0);
    exp_out.push_back('{1'b0, 2, 1'b0});
    pulse_start(2, 1'b1);
    n = 0;
    while (!(mgmt_write && mgmt_address == 6'd4) && n < 200) begin @(posedge clk); #1; n++; end
    chk("reach_wr_m", {31'd0, mgmt_write && mgmt_address == 6'd4}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_write", {31'd0, mgmt_write}, 32'd0);
    chk("arst_read", {31'd0, mgmt_read}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_addr", {26'd0, mgmt_address}, 32'd0);
    chk("arst_data", mgmt_writedata, 32'd0);
    chk("arst_error", {31'd0, error}, 32'd0);
    chk("arst_active", {30'd0, active_profile}, 32'd0);
    exp_wr.delete(); exp_out.delete();
    model_active = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);

`ifdef RECONFIG_VERIFY_EN
    run(1, 0, 1'b1, 0, 1'b0, 1'b1);
`endif

    for (int i = 0; i < 3; i++) begin
      run(int'($urandom_range(3)), int'($urandom_range(2)), 1'b1, 0, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
